iccm_port_arbiter: RTL and testbench
====================================

Name: iccm_port_arbiter

Overview:
Shares the single read/write port of the ICCM SRAM macro between two requesters.
- Requester 0 is the UART boot-load path, which writes program words.
- Requester 1 is the TL-UL instruction-memory adapter, which serves core fetches and debug accesses.
- The block handles grant arbitration, anti-starvation, SRAM strobe generation (active-low csb/web), and routing of read data with fixed latency back to the requester that issued the read.
- It sits between the requesters and the SRAM macro, inside the instruction-memory subsystem.

Parameters:
- AW, 11, SRAM word-address width.
- DW, 32, data width.
- NMASK, 4, write-mask width (one bit per byte).
- RD_LAT, 1, SRAM read latency in cycles, legal range 1..2.
- MAX_BURST, 8, maximum consecutive grants to requester 0 while requester 1 is waiting. Legal range 1..255.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- r0_req_i  in  1  requester 0 access request.
- r0_we_i  in  1  requester 0 write (1) / read (0).
- r0_addr_i  in  AW  requester 0 word address.
- r0_wdata_i  in  DW  requester 0 write data.
- r0_wmask_i  in  NMASK  requester 0 byte mask.
- r0_gnt_o  out  1  requester 0 grant; the access is accepted this cycle.
- r0_rvalid_o  out  1  requester 0 read data valid.
- r0_rdata_o  out  DW  requester 0 read data.
- r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i, r1_wmask_i, r1_gnt_o, r1_rvalid_o, r1_rdata_o: same directions, widths and meanings for requester 1.
- sram_csb_o  out  1  SRAM chip select, active low.
- sram_web_o  out  1  SRAM write enable, active low.
- sram_wmask_o  out  NMASK  SRAM byte mask.
- sram_addr_o  out  AW  SRAM address.
- sram_wdata_o  out  DW  SRAM write data.
- sram_rdata_i  in  DW  SRAM read data.
- busy_o  out  1  at least one read is in flight.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous, active-high.
- Reset values:
  - sram_csb_o=1, sram_web_o=1, sram_addr_o=0, sram_wdata_o=0, sram_wmask_o=0.
  - gnt/rvalid outputs=0, rdata outputs=0, busy_o=0.
  - Burst counter=0, in-flight pipeline cleared.
- Handshake:
  - A request is held with stable fields until granted.
  - gnt is combinational from req and the arbiter state, in the same cycle.
  - At most one gnt per cycle. gnt never asserts without the matching req.
- Arbitration (state CNT = 8-bit burst counter):
  - Only r0_req: grant 0.
  - Only r1_req: grant 1; CNT clears to 0.
  - Both requesting and CNT<MAX_BURST: grant 0; CNT increments.
  - Both requesting and CNT==MAX_BURST: grant 1; CNT clears to 0.
  - No grant to requester 0 while r1_req is low: CNT clears to 0.
  - CNT saturates and never wraps.
- SRAM drive:
  - On a grant, the granted request's fields are registered onto the sram_* outputs at the next clock edge.
  - sram_csb_o=0 for exactly one cycle per grant.
  - sram_web_o = ~we for that cycle.
  - With no grant, csb=1 and web=1. Address and data hold their last values.
- Read return:
  - For a granted read, a tag (requester id, valid) enters an RD_LAT-deep shift pipeline aligned to the csb cycle.
  - The tagged requester sees rvalid=1 for one cycle and rdata=sram_rdata_i registered, RD_LAT+1 cycles after gnt.
  - The other requester's rvalid stays 0 and its rdata holds its previous value.
  - Writes produce no rvalid.
- Throughput: back-to-back grants every cycle, with reads and writes interleaved freely. Pipelined reads return in issue order.
- busy_o: OR of the pipeline valid bits.
- Reset mid-operation: in-flight reads are dropped and no rvalid is emitted after reset. The SRAM write in the cycle of reset assertion is aborted asynchronously (csb forced to 1).
- Same-address write then read, back-to-back: the read returns the new data. This ordering is guaranteed by the SRAM sequencing, with no bypass.

Test Plan:
- Single reads:
  - r1 read addr 0x010 (SRAM holds 0xDEADBEEF), RD_LAT=1: r1_gnt in cycle 0; csb=0, web=1, addr=0x010 in cycle 1; r1_rvalid=1, r1_rdata=0xDEADBEEF in cycle 2; r0_rvalid stays 0.
  - Same read with RD_LAT=2: r1_rvalid in cycle 3.
- Starvation limit: r0 and r1 held requesting for 20 cycles, MAX_BURST=8. Grant sequence is 8×r0, 1×r1, 8×r0, 1×r1, 2×r0. A grant is issued every cycle.
- Write then read: r0 write addr 0x7FF, data 0x12345678, wmask 4'b0011. Then r1 reads 0x7FF, where SRAM previously held 0xAAAAAAAA. Required r1_rdata=0xAAAA5678; sram_wmask_o=4'b0011 in the write cycle.
- Interleaved reads: r0 read 0x001, r1 read 0x002, r0 read 0x003 on consecutive cycles. The rvalids follow in the same order, one per cycle, each with the matching data; busy_o stays 1 until the last rvalid.
- Reset mid-operation: rst_i asserted for 1 cycle one cycle after an r1 read grant. csb goes to 1 immediately, no r1_rvalid appears, all outputs return to reset values, and CNT=0.
- Idle and lone requests: with no requests, csb=1, web=1, gnt=0 indefinitely. A lone r0 request for 300 cycles is granted every cycle, and CNT saturates at 255 without wrapping.

Source files
------------

// File: rtl/iccm_port_arbiter.sv
// Two-requester arbiter for the single ICCM SRAM port: grant/anti-starvation,
// registered active-low SRAM strobes and fixed-latency read-data routing.
module iccm_port_arbiter #(
   parameter int AW        = 11,
   parameter int DW        = 32,
   parameter int NMASK     = 4,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,

   input  logic             r0_req_i,
   input  logic             r0_we_i,
   input  logic [AW-1:0]    r0_addr_i,
   input  logic [DW-1:0]    r0_wdata_i,
   input  logic [NMASK-1:0] r0_wmask_i,
   output logic             r0_gnt_o,
   output logic             r0_rvalid_o,
   output logic [DW-1:0]    r0_rdata_o,

   input  logic             r1_req_i,
   input  logic             r1_we_i,
   input  logic [AW-1:0]    r1_addr_i,
   input  logic [DW-1:0]    r1_wdata_i,
   input  logic [NMASK-1:0] r1_wmask_i,
   output logic             r1_gnt_o,
   output logic             r1_rvalid_o,
   output logic [DW-1:0]    r1_rdata_o,

   output logic             sram_csb_o,
   output logic             sram_web_o,
   output logic [NMASK-1:0] sram_wmask_o,
   output logic [AW-1:0]    sram_addr_o,
   output logic [DW-1:0]    sram_wdata_o,
   input  logic [DW-1:0]    sram_rdata_i,

   output logic             busy_o
);

   localparam logic [7:0] MAX_B = 8'(MAX_BURST);

   logic [7:0]        burst_cnt;
   logic [RD_LAT-1:0] pipe_v;
   logic [RD_LAT-1:0] pipe_id;
   logic              gnt0;
   logic              gnt1;
   logic              gnt_we;
   logic              ret_v;
   logic              ret_id;

   // Requester 0 wins unless requester 1 has waited out a full burst.
   always_comb begin
      gnt0   = ~rst_i & r0_req_i & (~r1_req_i | (burst_cnt < MAX_B));
      gnt1   = ~rst_i & r1_req_i & ~gnt0;
      gnt_we = gnt1 ? r1_we_i : r0_we_i;
   end

   assign r0_gnt_o = gnt0;
   assign r1_gnt_o = gnt1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         burst_cnt <= 8'd0;
      end else if (gnt0) begin
         if (burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
      end else begin
         burst_cnt <= 8'd0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sram_csb_o   <= 1'b1;
         sram_web_o   <= 1'b1;
         sram_wmask_o <= '0;
         sram_addr_o  <= '0;
         sram_wdata_o <= '0;
      end else if (gnt0 | gnt1) begin
         sram_csb_o   <= 1'b0;
         sram_web_o   <= ~gnt_we;
         sram_wmask_o <= gnt1 ? r1_wmask_i : r0_wmask_i;
         sram_addr_o  <= gnt1 ? r1_addr_i  : r0_addr_i;
         sram_wdata_o <= gnt1 ? r1_wdata_i : r0_wdata_i;
      end else begin
         sram_csb_o <= 1'b1;
         sram_web_o <= 1'b1;
      end
   end

   // Stage 0 lines up with the csb cycle; the last stage meets the SRAM data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pipe_v  <= '0;
         pipe_id <= '0;
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            pipe_v[i]  <= pipe_v[i-1];
            pipe_id[i] <= pipe_id[i-1];
         end
         pipe_v[0]  <= (gnt0 | gnt1) & ~gnt_we;
         pipe_id[0] <= gnt1;
      end
   end

   assign ret_v  = pipe_v[RD_LAT-1];
   assign ret_id = pipe_id[RD_LAT-1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r0_rvalid_o <= 1'b0;
         r1_rvalid_o <= 1'b0;
         r0_rdata_o  <= '0;
         r1_rdata_o  <= '0;
      end else begin
         r0_rvalid_o <= ret_v & ~ret_id;
         r1_rvalid_o <= ret_v & ret_id;
         if (ret_v & ~ret_id) r0_rdata_o <= sram_rdata_i;
         if (ret_v & ret_id)  r1_rdata_o <= sram_rdata_i;
      end
   end

   assign busy_o = |pipe_v;

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Directed bench: RD_LAT=1 instance (main) and RD_LAT=2 instance (latency only).
module tb_iccm_port_arbiter;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic        rst_i;
   logic        r0_req, r0_we, r1_req, r1_we;
   logic [10:0] r0_addr, r1_addr;
   logic [31:0] r0_wdata, r1_wdata;
   logic [3:0]  r0_wmask, r1_wmask;

   logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
   logic [31:0] r0_rdata, r1_rdata;
   logic        sram_csb, sram_web, busy;
   logic [3:0]  sram_wmask;
   logic [10:0] sram_addr;
   logic [31:0] sram_wdata, sram_rdata;

   logic        d2_r0_gnt, d2_r0_rvalid, d2_r1_gnt, d2_r1_rvalid;
   logic [31:0] d2_r0_rdata, d2_r1_rdata;
   logic        d2_csb, d2_web, d2_busy;
   logic [3:0]  d2_wmask;
   logic [10:0] d2_addr;
   logic [31:0] d2_wdata, d2_rdata;

   int vectors = 0;
   int miscompares = 0;

   iccm_port_arbiter #(.RD_LAT(1), .MAX_BURST(8)) u_dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_addr_i(r0_addr),
      .r0_wdata_i(r0_wdata), .r0_wmask_i(r0_wmask),
      .r0_gnt_o(r0_gnt), .r0_rvalid_o(r0_rvalid), .r0_rdata_o(r0_rdata),
      .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_addr_i(r1_addr),
      .r1_wdata_i(r1_wdata), .r1_wmask_i(r1_wmask),
      .r1_gnt_o(r1_gnt), .r1_rvalid_o(r1_rvalid), .r1_rdata_o(r1_rdata),
      .sram_csb_o(sram_csb), .sram_web_o(sram_web), .sram_wmask_o(sram_wmask),
      .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
      .busy_o(busy)
   );

   iccm_port_arbiter #(.RD_LAT(2), .MAX_BURST(8)) u_dut2 (
      .clk_i(clk_i), .rst_i(rst_i),
      .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_addr_i(r0_addr),
      .r0_wdata_i(r0_wdata), .r0_wmask_i(r0_wmask),
      .r0_gnt_o(d2_r0_gnt), .r0_rvalid_o(d2_r0_rvalid), .r0_rdata_o(d2_r0_rdata),
      .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_addr_i(r1_addr),
      .r1_wdata_i(r1_wdata), .r1_wmask_i(r1_wmask),
      .r1_gnt_o(d2_r1_gnt), .r1_rvalid_o(d2_r1_rvalid), .r1_rdata_o(d2_r1_rdata),
      .sram_csb_o(d2_csb), .sram_web_o(d2_web), .sram_wmask_o(d2_wmask),
      .sram_addr_o(d2_addr), .sram_wdata_o(d2_wdata), .sram_rdata_i(d2_rdata),
      .busy_o(d2_busy)
   );

   // SRAM models: preset contents reloaded while in reset, masked byte writes.
   logic [31:0] mem1 [0:2047];
   logic [31:0] mem2 [0:2047];
   logic [31:0] rd2;

   always @(posedge clk_i) begin
      if (rst_i) begin
         mem1[11'h010] <= 32'hDEADBEEF;
         mem1[11'h7FF] <= 32'hAAAAAAAA;
         mem1[11'h001] <= 32'h11111111;
         mem1[11'h002] <= 32'h22222222;
         mem1[11'h003] <= 32'h33333333;
      end else if (!sram_csb && !sram_web) begin
         for (int b = 0; b < 4; b++)
            if (sram_wmask[b]) mem1[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
   end
   assign sram_rdata = mem1[sram_addr];

   always @(posedge clk_i) begin
      if (rst_i) begin
         mem2[11'h010] <= 32'hDEADBEEF;
      end else if (!d2_csb) begin
         if (!d2_web) begin
            for (int b = 0; b < 4; b++)
               if (d2_wmask[b]) mem2[d2_addr][8*b +: 8] <= d2_wdata[8*b +: 8];
         end
         rd2 <= mem2[d2_addr];
      end
   end
   assign d2_rdata = rd2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic mid();
      @(negedge clk_i);
   endtask

   initial begin
      rst_i = 1'b1;
      r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0; r0_wmask = '0;
      r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0; r1_wmask = '0;

      repeat (2) @(posedge clk_i);
      mid();
      chk1("rst_csb", sram_csb, 1'b1);
      chk1("rst_web", sram_web, 1'b1);
      chk("rst_addr", 32'(sram_addr), 32'h0);
      chk("rst_wdata", sram_wdata, 32'h0);
      chk("rst_wmask", 32'(sram_wmask), 32'h0);
      chk1("rst_gnt0", r0_gnt, 1'b0);
      chk1("rst_gnt1", r1_gnt, 1'b0);
      chk1("rst_rvalid0", r0_rvalid, 1'b0);
      chk1("rst_rvalid1", r1_rvalid, 1'b0);
      chk("rst_rdata0", r0_rdata, 32'h0);
      chk("rst_rdata1", r1_rdata, 32'h0);
      chk1("rst_busy", busy, 1'b0);
      cyc();
      rst_i = 1'b0;

      // idle: no strobes, no grants
      for (int i = 0; i < 4; i++) begin
         mid();
         chk1("idle_csb", sram_csb, 1'b1);
         chk1("idle_web", sram_web, 1'b1);
         chk1("idle_gnt0", r0_gnt, 1'b0);
         chk1("idle_gnt1", r1_gnt, 1'b0);
         cyc();
      end

      // single r1 read of 0x010
      r1_req = 1; r1_we = 0; r1_addr = 11'h010;
      mid();
      chk1("rd_gnt1", r1_gnt, 1'b1);
      chk1("rd_gnt0", r0_gnt, 1'b0);
      cyc(); r1_req = 0;
      mid();
      chk1("rd_csb", sram_csb, 1'b0);
      chk1("rd_web", sram_web, 1'b1);
      chk("rd_addr", 32'(sram_addr), 32'h010);
      chk1("rd_busy", busy, 1'b1);
      chk1("rd_early_rvalid", r1_rvalid, 1'b0);
      cyc(); mid();
      chk1("rd_rvalid1", r1_rvalid, 1'b1);
      chk("rd_rdata1", r1_rdata, 32'hDEADBEEF);
      chk1("rd_rvalid0", r0_rvalid, 1'b0);
      chk1("rd_lat2_early", d2_r1_rvalid, 1'b0);
      cyc(); mid();
      chk1("rd_rvalid1_once", r1_rvalid, 1'b0);
      chk1("rd_csb_idle", sram_csb, 1'b1);
      chk1("rd_lat2_rvalid", d2_r1_rvalid, 1'b1);
      chk("rd_lat2_rdata", d2_r1_rdata, 32'hDEADBEEF);
      cyc(); mid();
      chk1("rd_lat2_once", d2_r1_rvalid, 1'b0);
      cyc();

      // r0 masked write to 0x7FF, then r1 read of the same word
      r0_req = 1; r0_we = 1; r0_addr = 11'h7FF; r0_wdata = 32'h12345678; r0_wmask = 4'b0011;
      mid();
      chk1("wr_gnt0", r0_gnt, 1'b1);
      cyc();
      r0_req = 0; r0_we = 0;
      r1_req = 1; r1_we = 0; r1_addr = 11'h7FF;
      mid();
      chk1("wr_csb", sram_csb, 1'b0);
      chk1("wr_web", sram_web, 1'b0);
      chk("wr_wmask", 32'(sram_wmask), 32'h3);
      chk("wr_wdata", sram_wdata, 32'h12345678);
      chk1("wr_rd_gnt1", r1_gnt, 1'b1);
      cyc(); r1_req = 0;
      mid();
      chk1("wr_no_rvalid0", r0_rvalid, 1'b0);
      chk1("wr_rd_web", sram_web, 1'b1);
      cyc(); mid();
      chk1("wr_rd_rvalid1", r1_rvalid, 1'b1);
      chk("wr_rd_rdata1", r1_rdata, 32'hAAAA5678);
      chk1("wr_rd_rvalid0", r0_rvalid, 1'b0);
      cyc(); cyc();

      // interleaved reads r0/r1/r0
      r0_req = 1; r0_we = 0; r0_addr = 11'h001;
      mid();
      chk1("il_gnt0_a", r0_gnt, 1'b1);
      cyc();
      r0_req = 0; r1_req = 1; r1_we = 0; r1_addr = 11'h002;
      mid();
      chk1("il_gnt1", r1_gnt, 1'b1);
      chk1("il_busy_1", busy, 1'b1);
      cyc();
      r1_req = 0; r0_req = 1; r0_addr = 11'h003;
      mid();
      chk1("il_gnt0_b", r0_gnt, 1'b1);
      chk1("il_rvalid0_a", r0_rvalid, 1'b1);
      chk("il_rdata0_a", r0_rdata, 32'h11111111);
      chk1("il_busy_2", busy, 1'b1);
      cyc(); r0_req = 0;
      mid();
      chk1("il_rvalid1", r1_rvalid, 1'b1);
      chk("il_rdata1", r1_rdata, 32'h22222222);
      chk1("il_rvalid0_gap", r0_rvalid, 1'b0);
      chk("il_rdata0_hold", r0_rdata, 32'h11111111);
      chk1("il_busy_3", busy, 1'b1);
      cyc(); mid();
      chk1("il_rvalid0_b", r0_rvalid, 1'b1);
      chk("il_rdata0_b", r0_rdata, 32'h33333333);
      chk1("il_rvalid1_off", r1_rvalid, 1'b0);
      chk("il_rdata1_hold", r1_rdata, 32'h22222222);
      cyc(); mid();
      chk1("il_busy_end", busy, 1'b0);
      chk1("il_rvalid0_off", r0_rvalid, 1'b0);
      cyc(); cyc();

      // both requesting for 20 cycles: 8 x r0, r1, 8 x r0, r1, 2 x r0
      r0_req = 1; r0_we = 0; r0_addr = 11'h001;
      r1_req = 1; r1_we = 0; r1_addr = 11'h002;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) cyc();
         mid();
         chk1($sformatf("sv_gnt0_%0d", i), r0_gnt, !(i == 8 || i == 17));
         chk1($sformatf("sv_gnt1_%0d", i), r1_gnt, (i == 8 || i == 17));
      end
      cyc(); r0_req = 0; r1_req = 0;
      repeat (3) cyc();

      // lone r0 for 300 cycles, counter saturates at 255
      r0_req = 1; r0_we = 1; r0_addr = 11'h100; r0_wdata = 32'h0BADF00D; r0_wmask = 4'hF;
      for (int i = 0; i < 300; i++) begin
         if (i > 0) cyc();
         mid();
         chk1("lone_gnt0", r0_gnt, 1'b1);
      end
      chk("lone_cnt_sat", 32'(u_dut.burst_cnt), 32'd255);
      cyc();
      r1_req = 1; r1_we = 0; r1_addr = 11'h002;
      mid();
      chk1("lone_then_gnt1", r1_gnt, 1'b1);
      chk1("lone_then_gnt0", r0_gnt, 1'b0);
      cyc(); mid();
      chk1("lone_after_gnt0", r0_gnt, 1'b1);
      chk("lone_after_cnt", 32'(u_dut.burst_cnt), 32'd0);
      cyc(); r0_req = 0; r0_we = 0; r1_req = 0;
      repeat (3) cyc();

      // reset one cycle after an r1 read grant
      r1_req = 1; r1_we = 0; r1_addr = 11'h010;
      mid();
      chk1("mr_gnt1", r1_gnt, 1'b1);
      cyc(); r1_req = 0;
      mid();
      chk1("mr_csb_pre", sram_csb, 1'b0);
      rst_i = 1'b1;
      #1;
      chk1("mr_csb_async", sram_csb, 1'b1);
      chk1("mr_busy_async", busy, 1'b0);
      cyc(); rst_i = 1'b0;
      mid();
      chk1("mr_rvalid1", r1_rvalid, 1'b0);
      chk("mr_rdata1", r1_rdata, 32'h0);
      chk("mr_rdata0", r0_rdata, 32'h0);
      chk("mr_addr", 32'(sram_addr), 32'h0);
      chk("mr_wdata", sram_wdata, 32'h0);
      chk1("mr_web", sram_web, 1'b1);
      chk("mr_cnt", 32'(u_dut.burst_cnt), 32'd0);
      cyc(); mid();
      chk1("mr_rvalid1_late", r1_rvalid, 1'b0);
      chk1("mr_csb", sram_csb, 1'b1);
      chk1("mr_busy", busy, 1'b0);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
